// File: rtl/pos_tracker_rpt_if.sv
// pos_tracker_rpt_if: pad-side and register-side signals of the cursor tracker.
//   dir_udlr  raw direction buttons [3]=up [2]=down [1]=left [0]=right (async)
//   wrap_en   1 = wrap at bounds, 0 = saturate
//   load      one-cycle position overwrite request, with load_x / load_y
//   x_pos, y_pos, at_edge, moved  tracker outputs
// master = stimulus / upstream side, slave = the tracker itself.
interface pos_tracker_rpt_if #(parameter int WIDTH = 8);
    logic [3:0]       dir_udlr;
    logic             wrap_en;
    logic             load;
    logic [WIDTH-1:0] load_x;
    logic [WIDTH-1:0] load_y;
    logic [WIDTH-1:0] x_pos;
    logic [WIDTH-1:0] y_pos;
    logic [3:0]       at_edge;
    logic             moved;

    modport master (output dir_udlr, wrap_en, load, load_x, load_y,
                    input  x_pos, y_pos, at_edge, moved);
    modport slave  (input  dir_udlr, wrap_en, load, load_x, load_y,
                    output x_pos, y_pos, at_edge, moved);
endinterface

// File: rtl/pos_tracker_rpt.sv
// pos_tracker_rpt: X/Y cursor tracker with synchronised buttons, tap-then-
// auto-repeat stepping, bounds with wrap/saturate, and a load port.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         pos_tracker_rpt_if.slave (buttons, wrap_en, load in;
//               x_pos, y_pos, at_edge, moved out)
// Optional macro POS_TRACKER_ACCEL_EN: after 8 steps in the repeat phase an
// axis steps by 2*STEP until it idles, reverses or is loaded.

// One axis: press/repeat FSM, repeat counter and position register.
module pos_tracker_axis #(
    parameter int WIDTH         = 8,
    parameter int MAX           = 159,
    parameter int RESET         = 80,
    parameter int STEP          = 1,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    input  logic             wrap_en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] pos,
    output logic             chg
);
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX);
    localparam logic [WIDTH:0]   MAX_E   = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0]   MAX_P1  = (WIDTH+1)'(MAX + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;      // 1 = last press was '+'
    logic [WIDTH-1:0] pos_q, pos_d;
    logic             net_any, net_up, step;
    logic [WIDTH:0]   step_amt, pe, sum, plus_v, minus_v;
    logic [WIDTH-1:0] step_val;

    assign net_any = inc ^ dec;          // both or neither -> no direction
    assign net_up  = inc & ~dec;

`ifdef POS_TRACKER_ACCEL_EN
    logic [3:0] rpt_q, rpt_d;            // steps taken in REPEAT, saturates at 8
    assign step_amt = (rpt_q == 4'd8) ? (WIDTH+1)'(2*STEP) : (WIDTH+1)'(STEP);
`else
    assign step_amt = (WIDTH+1)'(STEP);
`endif

    // Candidate next position for a step in the current net direction.
    always_comb begin
        pe  = {1'b0, pos_q};
        sum = pe + step_amt;
        if (sum > MAX_E) plus_v = wrap_en ? (sum - MAX_P1) : MAX_E;
        else             plus_v = sum;
        if (pe < step_amt) minus_v = wrap_en ? (pe + MAX_P1 - step_amt) : '0;
        else               minus_v = pe - step_amt;
        step_val = net_up ? WIDTH'(plus_v) : WIDTH'(minus_v);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pos_d   = pos_q;
        step    = 1'b0;
`ifdef POS_TRACKER_ACCEL_EN
        rpt_d   = rpt_q;
`endif
        if (load) begin
            state_d = IDLE;
            cnt_d   = '0;
            pos_d   = (load_val > MAX_W) ? MAX_W : load_val;
`ifdef POS_TRACKER_ACCEL_EN
            rpt_d   = '0;
`endif
        end else if (!net_any) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef POS_TRACKER_ACCEL_EN
            rpt_d   = '0;
`endif
        end else if (state_q == IDLE || net_up != dir_q) begin
            // fresh press or reversal: step now and restart the delay
            step    = 1'b1;
            cnt_d   = CW'(1);
            state_d = DELAY;
            dir_d   = net_up;
`ifdef POS_TRACKER_ACCEL_EN
            rpt_d   = '0;
`endif
        end else if (state_q == DELAY) begin
            if (cnt_q == CW'(REPEAT_DELAY)) begin
                step    = 1'b1;
                cnt_d   = CW'(1);
                state_d = REPEAT;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            if (cnt_q == CW'(REPEAT_PERIOD)) begin
                step  = 1'b1;
                cnt_d = CW'(1);
`ifdef POS_TRACKER_ACCEL_EN
                if (rpt_q != 4'd8) rpt_d = rpt_q + 4'd1;
`endif
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (step) pos_d = step_val;
    end

    // A saturated step that leaves the position unchanged is not a move.
    assign chg = step && (step_val != pos_q);
    assign pos = pos_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            pos_q   <= WIDTH'(RESET);
`ifdef POS_TRACKER_ACCEL_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pos_q   <= pos_d;
`ifdef POS_TRACKER_ACCEL_EN
            rpt_q   <= rpt_d;
`endif
        end
    end
endmodule

module pos_tracker_rpt #(
    parameter int WIDTH         = 8,
    parameter int X_MAX         = 159,
    parameter int Y_MAX         = 119,
    parameter int X_RESET       = 80,
    parameter int Y_RESET       = 60,
    parameter int STEP          = 1,
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pos_tracker_rpt_if.slave  bus
);
    logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic             moved_q, moved_d;
    logic             x_chg, y_chg;
    logic [WIDTH-1:0] x_q, y_q;

    always_comb begin
        sync1_d = bus.dir_udlr;
        sync2_d = sync1_q;
        moved_d = x_chg | y_chg;         // one pulse even if both axes step
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            moved_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            moved_q <= moved_d;
        end
    end

    pos_tracker_axis #(.WIDTH(WIDTH), .MAX(X_MAX), .RESET(X_RESET), .STEP(STEP),
                       .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_x (
        .clk(clk), .rst_n(rst_n), .inc(sync2_q[0]), .dec(sync2_q[1]),
        .wrap_en(bus.wrap_en), .load(bus.load), .load_val(bus.load_x),
        .pos(x_q), .chg(x_chg));

    pos_tracker_axis #(.WIDTH(WIDTH), .MAX(Y_MAX), .RESET(Y_RESET), .STEP(STEP),
                       .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_y (
        .clk(clk), .rst_n(rst_n), .inc(sync2_q[3]), .dec(sync2_q[2]),
        .wrap_en(bus.wrap_en), .load(bus.load), .load_val(bus.load_y),
        .pos(y_q), .chg(y_chg));

    assign bus.x_pos   = x_q;
    assign bus.y_pos   = y_q;
    assign bus.moved   = moved_q;
    assign bus.at_edge = {y_q == WIDTH'(Y_MAX), y_q == '0, x_q == '0, x_q == WIDTH'(X_MAX)};
endmodule

// File: tb/tb_pos_tracker_rpt.sv
// Self-checking bench for pos_tracker_rpt: constant vector table, hand-written
// multi-cycle sequences, and randomized stimulus against a reference model.
module tb_pos_tracker_rpt;
    localparam int XM = 159, YM = 119, XR = 80, YR = 60, ST = 1, RD = 16, RP = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pos_tracker_rpt_if #(.WIDTH(8)) bus ();
    pos_tracker_rpt #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    int pulse_q[$];

    // Reference model: position plus "age" of the current press per axis.
    int mx, my, agex, agey, pnx, pny;
    logic [3:0] ms1, ms2;
    logic mmoved;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] edge_of(input int x, input int y);
        return {y == YM, y == 0, x == 0, x == XM};
    endfunction

    function automatic int step_to(input int p, input int net, input int s,
                                   input int maxv, input bit w);
        if (net > 0) return (p + s > maxv) ? (w ? (p + s) % (maxv + 1) : maxv) : p + s;
        else         return (p < s) ? (w ? p - s + maxv + 1 : 0) : p - s;
    endfunction

    task automatic model_reset();
        mx = XR; my = YR; agex = -1; agey = -1; pnx = 0; pny = 0;
        ms1 = '0; ms2 = '0; mmoved = 1'b0;
    endtask

    // Steps happen at press age 0, at age RD, then every RP cycles.
    task automatic m_axis(inout int p, inout int age, inout int pnet, input int net,
                          input bit w, input bit ld, input int lv, input int maxv,
                          output bit ch);
        bit st;
        int s, np;
        ch = 1'b0; st = 1'b0; s = ST;
        if (ld) begin
            p = (lv > maxv) ? maxv : lv; age = -1;
        end else if (net == 0) begin
            age = -1;
        end else begin
            if (age < 0 || net != pnet) begin
                age = 0; pnet = net; st = 1'b1;
            end else begin
                age++;
                if (age == RD) st = 1'b1;
                else if (age > RD && (age - RD) % RP == 0) begin
                    st = 1'b1;
`ifdef POS_TRACKER_ACCEL_EN
                    if ((age - RD) / RP >= 9) s = 2 * ST;
`endif
                end
            end
            if (st) begin
                np = step_to(p, net, s, maxv, w);
                ch = (np != p);
                p = np;
            end
        end
    endtask

    task automatic m_edge(input logic [3:0] d, input bit w, input bit ld,
                          input int lx, input int ly);
        logic [3:0] u;
        int nx, ny;
        bit cx, cy;
        u = ms2; ms2 = ms1; ms1 = d;
        nx = (u[0] && !u[1]) ? 1 : ((u[1] && !u[0]) ? -1 : 0);
        ny = (u[3] && !u[2]) ? 1 : ((u[2] && !u[3]) ? -1 : 0);
        m_axis(mx, agex, pnx, nx, w, ld, lx, XM, cx);
        m_axis(my, agey, pny, ny, w, ld, ly, YM, cy);
        mmoved = cx | cy;
    endtask

    // One clock: drive at negedge, model the edge, compare at next negedge.
    task automatic cycle(input logic [3:0] d, input bit w, input bit ld,
                         input int lx, input int ly);
        bus.dir_udlr = d; bus.wrap_en = w; bus.load = ld;
        bus.load_x = 8'(lx); bus.load_y = 8'(ly);
        @(posedge clk);
        m_edge(d, w, ld, lx, ly);
        @(negedge clk);
        chk("model_x", int'(bus.x_pos), mx);
        chk("model_y", int'(bus.y_pos), my);
        chk("model_moved", int'(bus.moved), int'(mmoved));
        chk("model_edge", int'(bus.at_edge), int'(edge_of(mx, my)));
        if (bus.moved) pulse_q.push_back(cyc);
        cyc++;
    endtask

    task automatic hold(input logic [3:0] d, input bit w, input int n);
        for (int i = 0; i < n; i++) cycle(d, w, 1'b0, 0, 0);
    endtask

    task automatic seq_start();
        cyc = 0;
        pulse_q.delete();
    endtask

    typedef struct {
        logic [3:0] dir; bit wrap; bit ld; int lx; int ly;
        int ex; int ey; bit em;
    } vec_t;
    vec_t tbl[18];

    initial begin
        int rep_exp[7] = '{2, 18, 22, 26, 30, 34, 38};
        int rev_exp[3] = '{2, 12, 28};
        int yb;
        bit got;
        logic [3:0] rd;
        bit rw;
        int hl;

        tbl[0]  = '{4'b0001, 0, 0,   0,   0,  80,  60, 0};
        tbl[1]  = '{4'b0001, 0, 0,   0,   0,  80,  60, 0};
        tbl[2]  = '{4'b0001, 0, 0,   0,   0,  81,  60, 1};
        tbl[3]  = '{4'b0000, 0, 0,   0,   0,  81,  60, 0};
        tbl[4]  = '{4'b0000, 0, 0,   0,   0,  81,  60, 0};
        tbl[5]  = '{4'b0000, 0, 0,   0,   0,  81,  60, 0};
        tbl[6]  = '{4'b0000, 0, 1, 200,  50, 159,  50, 0};
        tbl[7]  = '{4'b1000, 0, 0,   0,   0, 159,  50, 0};
        tbl[8]  = '{4'b1000, 0, 0,   0,   0, 159,  50, 0};
        tbl[9]  = '{4'b1000, 0, 0,   0,   0, 159,  51, 1};
        tbl[10] = '{4'b0000, 0, 1,   0, 119,   0, 119, 0};
        tbl[11] = '{4'b0000, 0, 0,   0,   0,   0, 119, 0};
        tbl[12] = '{4'b0000, 1, 0,   0,   0,   0, 119, 0};
        tbl[13] = '{4'b0010, 1, 0,   0,   0,   0, 119, 0};
        tbl[14] = '{4'b0010, 1, 0,   0,   0,   0, 119, 0};
        tbl[15] = '{4'b0010, 1, 0,   0,   0, 159, 119, 1};
        tbl[16] = '{4'b0000, 1, 0,   0,   0, 159, 119, 0};
        tbl[17] = '{4'b0000, 1, 0,   0,   0, 159, 119, 0};

        // reset
        rst_n = 1'b0;
        bus.dir_udlr = '0; bus.wrap_en = 1'b0; bus.load = 1'b0;
        bus.load_x = '0; bus.load_y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_x", int'(bus.x_pos), 80);
        chk("rst_y", int'(bus.y_pos), 60);
        chk("rst_moved", int'(bus.moved), 0);
        chk("rst_edge", int'(bus.at_edge), 0);
        rst_n = 1'b1;
        hold(4'b0000, 0, 5);
        chk("idle_x", int'(bus.x_pos), 80);
        chk("idle_y", int'(bus.y_pos), 60);

        // vector table
        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].dir, tbl[i].wrap, tbl[i].ld, tbl[i].lx, tbl[i].ly);
            chk($sformatf("tbl%0d_x", i), int'(bus.x_pos), tbl[i].ex);
            chk($sformatf("tbl%0d_y", i), int'(bus.y_pos), tbl[i].ey);
            chk($sformatf("tbl%0d_moved", i), int'(bus.moved), int'(tbl[i].em));
            chk($sformatf("tbl%0d_edge", i), int'(bus.at_edge), int'(edge_of(tbl[i].ex, tbl[i].ey)));
        end

        // async reset in the middle of an auto-repeat, button still held
        hold(4'b0001, 0, 25);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_x", int'(bus.x_pos), 80);
        chk("mrst_y", int'(bus.y_pos), 60);
        chk("mrst_moved", int'(bus.moved), 0);
        chk("mrst_edge", int'(bus.at_edge), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seq_start();
        hold(4'b0001, 0, 4);
        hold(4'b0000, 0, 3);
        chk("mrst_npulse", pulse_q.size(), 1);
        if (pulse_q.size() > 0) chk("mrst_pulse_at", pulse_q[0], 2);
        chk("mrst_x_after", int'(bus.x_pos), 81);

        // auto-repeat
        cycle(4'b0000, 0, 1'b1, 80, 60);
        hold(4'b0000, 0, 2);
        seq_start();
        hold(4'b0001, 0, 40);
        hold(4'b0000, 0, 4);
        chk("rep_npulse", pulse_q.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < pulse_q.size()) chk($sformatf("rep_pulse%0d", i), pulse_q[i], rep_exp[i]);
        chk("rep_x", int'(bus.x_pos), 87);

        // reversal with no gap
        seq_start();
        hold(4'b0001, 0, 10);
        hold(4'b0010, 0, 19);
        hold(4'b0000, 0, 4);
        chk("rev_npulse", pulse_q.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < pulse_q.size()) chk($sformatf("rev_pulse%0d", i), pulse_q[i], rev_exp[i]);
        chk("rev_x", int'(bus.x_pos), 86);

        // up+down cancel
        seq_start();
        hold(4'b1100, 0, 30);
        hold(4'b0000, 0, 4);
        chk("cancel_npulse", pulse_q.size(), 0);
        chk("cancel_y", int'(bus.y_pos), 60);

        // bounds: saturate at top, then wrap
        cycle(4'b0000, 0, 1'b1, 86, 119);
        hold(4'b0000, 0, 2);
        seq_start();
        hold(4'b1000, 0, 30);
        chk("sat_npulse", pulse_q.size(), 0);
        chk("sat_y", int'(bus.y_pos), 119);
        chk("sat_edge3", int'(bus.at_edge[3]), 1);
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            cycle(4'b1000, 1, 1'b0, 0, 0);
            if (bus.moved) begin
                got = 1'b1;
                chk("wrap_y", int'(bus.y_pos), 0);
            end
        end
        if (!got) chk("wrap_timeout", 0, 1);
        hold(4'b0000, 1, 4);
        cycle(4'b0000, 1, 1'b1, 0, 60);
        hold(4'b0000, 1, 2);
        hold(4'b0010, 1, 3);
        hold(4'b0000, 1, 4);
        chk("wrap_left_x", int'(bus.x_pos), 159);

        // load priority during repeat
        cycle(4'b0000, 0, 1'b1, 80, 60);
        hold(4'b0000, 0, 2);
        hold(4'b0001, 0, 25);
        cycle(4'b0001, 0, 1'b1, 200, 50);
        chk("ld_x_clamp", int'(bus.x_pos), 159);
        chk("ld_y", int'(bus.y_pos), 50);
        chk("ld_moved", int'(bus.moved), 0);
        cycle(4'b0001, 0, 1'b0, 0, 0);
        chk("ld_sat_x", int'(bus.x_pos), 159);
        chk("ld_sat_moved", int'(bus.moved), 0);
        cycle(4'b0001, 0, 1'b1, 10, 50);
        chk("ld2_x", int'(bus.x_pos), 10);
        cycle(4'b0001, 0, 1'b0, 0, 0);
        chk("ld2_step_x", int'(bus.x_pos), 11);
        chk("ld2_step_moved", int'(bus.moved), 1);
        hold(4'b0000, 0, 4);

`ifdef POS_TRACKER_ACCEL_EN
        cycle(4'b0000, 0, 1'b1, 0, 60);
        hold(4'b0000, 0, 2);
        seq_start();
        for (int i = 0; i < 56; i++) begin
            cycle(4'b0001, 0, 1'b0, 0, 0);
            if (i == 50) chk("accel_x50", int'(bus.x_pos), 10);
            if (i == 54) chk("accel_x54", int'(bus.x_pos), 12);
        end
        hold(4'b0000, 0, 4);
`endif

        // randomized against the model
        rd = '0; rw = 1'b0; hl = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hl == 0) begin
                rd = 4'($urandom_range(0, 15));
                hl = $urandom_range(1, 45);
                if ($urandom_range(0, 3) == 0) rw = ~rw;
            end
            hl--;
            cycle(rd, rw, ($urandom_range(0, 40) == 0), $urandom_range(0, 255), $urandom_range(0, 255));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pos_tracker_rpt.md
Name: pos_tracker_rpt

Overview:
- Parametrised next-generation X/Y cursor tracker driven by four direction buttons.
- Adds input synchronisation, tap-then-auto-repeat stepping, configurable bounds and step, wrap/saturate mode, and a load port.
- Outputs position, edge flags and a move pulse.
- Sits between the pad inputs and the I2C slave register map, replacing the fixed 8-bit tracker.

Parameters:
- WIDTH, 8, coordinate width in bits.
- X_MAX, 159, largest legal x (must be < 2^WIDTH).
- Y_MAX, 119, largest legal y (must be < 2^WIDTH).
- X_RESET, 80, x value after reset (≤ X_MAX).
- Y_RESET, 60, y value after reset (≤ Y_MAX).
- STEP, 1, coordinate change per step (1 ≤ STEP ≤ min(X_MAX, Y_MAX)).
- REPEAT_DELAY, 16, cycles from the first step to the first auto-repeat step (≥ 2).
- REPEAT_PERIOD, 4, cycles between auto-repeat steps (≥ 1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- dir_udlr  in  4  raw buttons: [3]=up (+y), [2]=down (−y), [1]=left (−x), [0]=right (+x). Asynchronous.
- wrap_en  in  1  1 = wrap at bounds, 0 = saturate. Synchronous, sampled every cycle.
- load  in  1  one-cycle request to overwrite position.
- load_x  in  WIDTH  x value for load.
- load_y  in  WIDTH  y value for load.
- x_pos  out  WIDTH  current x.
- y_pos  out  WIDTH  current y.
- at_edge  out  4  [3]=y==Y_MAX, [2]=y==0, [1]=x==0, [0]=x==X_MAX; decoded from the position registers.
- moved  out  1  one-cycle pulse, registered together with the position, when a step changes x or y.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: x_pos=X_RESET, y_pos=Y_RESET, moved=0, sync flops=0, both axis FSMs IDLE, counters 0. at_edge follows from the reset position.
- Synchroniser: dir_udlr passes through 2 flops. Raw assertion before edge k gives the first step at edge k+2.
- Net direction per axis:
  - up&~down gives +, down&~up gives −.
  - Both or neither gives none (the axis idles).
- Per-axis FSM (x and y independent), one counter per axis:
  - IDLE: net≠none → step now, counter=1, go to DELAY.
  - DELAY: when counter reaches REPEAT_DELAY → step, counter=1, go to REPEAT; else counter++.
  - REPEAT: when counter reaches REPEAT_PERIOD → step, counter=1; else counter++.
  - Any state: net=none → IDLE, counter=0.
  - Net direction reverses (+↔−) → treated as a new press: step in the new direction this cycle, counter=1, go to DELAY.
- Step arithmetic uses a WIDTH+1-bit intermediate.
  - Saturate: +: min(p+STEP, MAX); −: max(p−STEP, 0).
  - Wrap, +: if p+STEP>MAX then p+STEP−(MAX+1).
  - Wrap, −: if p<STEP then p+(MAX+1)−STEP.
  - A saturated step that leaves p unchanged does not pulse moved.
- Load:
  - Highest priority. Next cycle x=min(load_x, X_MAX) and y=min(load_y, Y_MAX).
  - Both FSMs go to IDLE and counters clear; that cycle's steps are suppressed; moved=0.
  - A still-held direction re-triggers as a new press on the following cycle.
- Simultaneous x and y steps in one cycle are both applied; moved pulses once.
- Reset mid-repeat: immediate return to reset values; no step is emitted on release of reset until the synchroniser refills (2 cycles).

Optional Feature:
- Macro: POS_TRACKER_ACCEL_EN.
- Defined:
  - Each axis counts consecutive REPEAT-state steps (saturating at 8).
  - After 8 repeats on an axis, that axis steps by 2*STEP (same bound rules).
  - The repeat count clears on IDLE, reversal or load.
- Undefined: step is always STEP and no repeat-count logic is synthesised.

Test Plan:
- Reset: assert rst_n=0 async mid-cycle → x_pos=80, y_pos=60, moved=0, at_edge=4'b0000 immediately; hold 5 cycles after release with no buttons → unchanged.
- Tap: right high for edges k..k+2 → x_pos=81 at edge k+2 only, moved high exactly one cycle, no further steps.
- Auto-repeat (accel off): right held for edges k..k+39 → steps at k+2, k+18, k+22, k+26, k+30, k+34, k+38; final x_pos=87, 7 moved pulses.
- Bounds:
  - load_y=119, wrap_en=0, hold up 30 cycles → y stays 119, at_edge[3]=1, no moved pulse.
  - Set wrap_en=1 → next step gives y=0.
  - load_x=0, wrap_en=1, tap left → x=159.
- Cancel/reversal: up+down held together → y constant. Right held 10 cycles, then left (no gap) → first left step on the 3rd edge after the switch, then a fresh 16-cycle delay.
- Load priority: load=1 with load_x=200, load_y=50 while right is in REPEAT → x=159 (clamped), y=50, no step that cycle, first new step one cycle later. With POS_TRACKER_ACCEL_EN defined, 9th repeat step moves by 2.
